// File: rtl/oai22_bank_actmon.sv
// oai22_bank_actmon: pipelined bank of OAI22 channels with per-channel
// output-toggle counters and a request/acknowledge counter readout port.
module oai22_bank_actmon #(
    parameter int CH    = 4,
    parameter int CNT_W = 16,
    parameter int SEL_W = 2
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             EN,
    input  logic [CH-1:0]    IN1,
    input  logic [CH-1:0]    IN2,
    input  logic [CH-1:0]    IN3,
    input  logic [CH-1:0]    IN4,
    output logic [CH-1:0]    QN,
    input  logic             CLR,
    input  logic             RD_REQ,
    input  logic [SEL_W-1:0] RD_SEL,
    output logic             RD_ACK,
    output logic [CNT_W-1:0] RD_DATA,
    output logic [CH-1:0]    SAT
);
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;
    state_t state, nxt;
    logic [CH-1:0] r1, r2, r3, r4, qn_nxt, tog;
    logic [CNT_W-1:0] cnt [CH];
    logic [CNT_W-1:0] sel_cnt;
    assign qn_nxt = ~((r1 | r2) & (r3 | r4));
    assign tog    = qn_nxt ^ QN;
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            r4 <= '0;
            QN <= '1;
        end else begin
            if (EN) begin
                r1 <= IN1;
                r2 <= IN2;
                r3 <= IN3;
                r4 <= IN4;
            end
            QN <= qn_nxt;
        end
    end
    // Saturated channels keep their count; further toggles only latch SAT.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            SAT <= '0;
            for (int c = 0; c < CH; c++) cnt[c] <= '0;
        end else if (CLR) begin
            SAT <= '0;
            for (int c = 0; c < CH; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (tog[c]) begin
                    if (cnt[c] == '1) SAT[c] <= 1'b1;
                    else cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end
    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_cnt = '0;
        for (int c = 0; c < CH; c++)
            if (RD_SEL == SEL_W'(c)) sel_cnt = cnt[c];
    end
    always_comb begin
        nxt    = (state == S_IDLE) ? (RD_REQ ? S_ACK : S_IDLE) :
                 (state == S_ACK)  ? S_WAIT :
                 (RD_REQ ? S_WAIT : S_IDLE);
        RD_ACK = (state == S_ACK);
    end
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state   <= S_IDLE;
            RD_DATA <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && RD_REQ) RD_DATA <= sel_cnt;
        end
    end
endmodule

// File: tb/tb_oai22_bank_actmon.sv
// tb_oai22_bank_actmon: directed vectors plus hand-written readout/clear/reset
// sequences for a CH=4, CNT_W=4 bank.
module tb_oai22_bank_actmon;
    logic       CLK = 0, RSTB = 0, EN = 0, CLR = 0, RD_REQ = 0;
    logic [3:0] IN1 = 0, IN2 = 0, IN3 = 0, IN4 = 0, QN, SAT, RD_DATA;
    logic [2:0] RD_SEL = 0;
    logic       RD_ACK;
    int         n_vec = 0, n_err = 0;

    oai22_bank_actmon #(.CH(4), .CNT_W(4), .SEL_W(3)) dut (
        .CLK(CLK), .RSTB(RSTB), .EN(EN), .IN1(IN1), .IN2(IN2), .IN3(IN3),
        .IN4(IN4), .QN(QN), .CLR(CLR), .RD_REQ(RD_REQ), .RD_SEL(RD_SEL),
        .RD_ACK(RD_ACK), .RD_DATA(RD_DATA), .SAT(SAT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic [3:0] i1, i2, i3, i4;
        logic       clr;
        logic [3:0] qn;
    } vec_t;
    vec_t tbl [21];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            EN = tbl[i].en; IN1 = tbl[i].i1; IN2 = tbl[i].i2;
            IN3 = tbl[i].i3; IN4 = tbl[i].i4; CLR = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_qn", i), 32'(QN), 32'(tbl[i].qn));
        end
        EN = 0; CLR = 0;
    endtask

    task automatic read_ch(input int sel, input int exp);
        RD_REQ = 1; RD_SEL = 3'(sel);
        tick();
        chk($sformatf("rd%0d_ack", sel), 32'(RD_ACK), 1);
        chk($sformatf("rd%0d_data", sel), 32'(RD_DATA), 32'(exp));
        RD_REQ = 0;
        tick();
        chk($sformatf("rd%0d_ack_drop", sel), 32'(RD_ACK), 0);
        tick();
    endtask

    task automatic toggle_ch(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            IN1[ch] = ~IN1[ch]; EN = 1;
            tick();
        end
        EN = 0;
        tick();
    endtask

    initial begin
        int acks;
        //         en  i1     i2     i3     i4     clr  qn
        tbl[0]  = '{1, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'hF};
        tbl[1]  = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'h0};
        tbl[2]  = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'h0};
        tbl[3]  = '{1, 4'h0, 4'hF, 4'h0, 4'hF, 0, 4'h0};
        tbl[4]  = '{1, 4'h0, 4'h3, 4'h5, 4'h0, 0, 4'h0};
        tbl[5]  = '{1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'hE};
        tbl[6]  = '{1, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'hF};
        tbl[7]  = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'h0};
        tbl[8]  = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 1, 4'h0};
        for (int k = 0; k < 10; k++)
            tbl[9+k] = '{1, (k % 2 == 0) ? 4'hB : 4'hF, 4'h0, 4'hF, 4'h0, 0,
                         (k % 2 == 1) ? 4'h4 : 4'h0};
        tbl[19] = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'h0};
        tbl[20] = '{0, 4'hF, 4'h0, 4'hF, 4'h0, 0, 4'h0};

        tick(); tick();
        chk("rst_qn", 32'(QN), 32'hF);
        chk("rst_ack", 32'(RD_ACK), 0);
        chk("rst_data", 32'(RD_DATA), 0);
        chk("rst_sat", 32'(SAT), 0);
        RSTB = 1;

        apply(0, 2);
        read_ch(0, 1);
        read_ch(3, 1);

        apply(3, 20);
        read_ch(2, 10);
        read_ch(0, 0);
        read_ch(1, 0);
        read_ch(3, 0);
        chk("sat_none", 32'(SAT), 0);

        toggle_ch(1, 20);
        chk("sat_ch1", 32'(SAT), 32'h2);
        chk("qn_after_sat", 32'(QN), 32'h0);
        read_ch(1, 15);
        read_ch(2, 10);
        CLR = 1;
        tick();
        CLR = 0;
        chk("sat_cleared", 32'(SAT), 0);
        read_ch(1, 0);
        read_ch(2, 0);

        toggle_ch(0, 7);
        IN1[3] = ~IN1[3]; EN = 1;
        tick();
        EN = 0; CLR = 1; RD_REQ = 1; RD_SEL = 0;
        tick();
        chk("clrrd_ack", 32'(RD_ACK), 1);
        chk("clrrd_data", 32'(RD_DATA), 7);
        chk("clrrd_qn", 32'(QN), 32'h9);
        CLR = 0; RD_REQ = 0;
        tick(); tick();
        read_ch(3, 0);
        read_ch(0, 0);

        toggle_ch(1, 3);
        chk("qn_b", 32'(QN), 32'hB);
        acks = 0;
        RD_REQ = 1; RD_SEL = 2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RD_ACK) acks++;
        end
        chk("hold_acks", 32'(acks), 1);
        RD_REQ = 0;
        tick();
        RD_REQ = 1; RD_SEL = 1;
        tick();
        chk("rereq_ack", 32'(RD_ACK), 1);
        chk("rereq_data", 32'(RD_DATA), 3);
        RD_REQ = 0;
        tick(); tick();
        read_ch(5, 0);

        EN = 0;
        IN1 = 0; IN2 = 0; IN3 = 0; IN4 = 0;
        tick();
        IN1 = 4'hF;
        tick();
        IN3 = 4'hA; IN2 = 4'h5;
        tick();
        chk("en0_qn", 32'(QN), 32'hB);
        read_ch(1, 3);

        RD_REQ = 1; RD_SEL = 1;
        tick();
        chk("prerst_ack", 32'(RD_ACK), 1);
        RSTB = 0;
        #1;
        chk("midrst_ack", 32'(RD_ACK), 0);
        chk("midrst_qn", 32'(QN), 32'hF);
        chk("midrst_data", 32'(RD_DATA), 0);
        #1;
        RSTB = 1; RD_REQ = 0;
        tick();
        chk("postrst_ack", 32'(RD_ACK), 0);
        chk("postrst_qn", 32'(QN), 32'hF);
        read_ch(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
